mpeg2_pixel_loader: RTL and testbench

Double-buffered pixel input stage that feeds the MPEG-2 encoder core. The CPU writes 32-bit words, four 8-bit pixels each, into one of two block banks over the same 8-bit-address register bus the encoder uses. When a bank holds a complete block it is marked full. The bank is then streamed downstream one pixel per cycle over a valid/ready handshake, while the CPU fills the other bank.

---
 rtl/mpeg2_pixel_loader.sv | 199 +++++++++++++++++++
 tb/tb_mpeg2_pixel_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpeg2_pixel_loader.sv
// Double-buffered pixel loader: CPU fills one bank while the other streams out.
// Define PIXLOADER_OVERFLOW_EN to build the sticky overflow flag and CTRL clear.
module mpeg2_pixel_loader #(
    parameter int WORDS_PER_BLOCK = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic [7:0]  pix_out,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        block_start,
    output logic        block_end
);

    localparam int AW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam logic [AW-1:0] LAST = AW'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND
    } state_t;

    state_t        r_state;
    logic          r_wb;
    logic          r_rb;
    logic [AW-1:0] r_wr_idx;
    logic [AW-1:0] r_rd_idx;
    logic [1:0]    r_bi;
    logic [1:0]    r_full;
    logic [31:0]   r_shift;
    logic [31:0]   r_rdata;
    logic          r_valid;
    logic          r_start;
    logic          r_end;
    logic [31:0]   r_mem [0:2*WORDS_PER_BLOCK-1];

    logic          w_data_wr;
    logic          w_wr_ok;
    logic          w_wr_last;
    logic          w_rd_last;
    logic          w_acc;
    logic          w_word_done;
    logic          w_release;
    logic          w_rd_issue;
    logic [AW-1:0] w_rd_next;
    logic [AW:0]   w_rd_addr;
    logic [1:0]    w_set;
    logic [1:0]    w_clr;
    logic          w_overflow;
    logic [5:0]    w_wr_idx6;
    logic [31:0]   w_status;

    assign w_data_wr   = wr_en && (addr == 8'h04);
    assign w_wr_ok     = w_data_wr && !r_full[r_wb];
    assign w_wr_last   = w_wr_ok && (r_wr_idx == LAST);
    assign w_rd_last   = (r_rd_idx == LAST);
    assign w_acc       = (r_state == S_SEND) && pix_ready;
    assign w_word_done = w_acc && (r_bi == 2'd3);
    assign w_release   = w_word_done && w_rd_last;
    assign w_rd_next   = r_rd_idx + AW'(1);

    // Next word is fetched on the last byte's acceptance, costing one bubble.
    assign w_rd_issue = ((r_state == S_IDLE) && r_full[r_rb])
                      || (w_word_done && !w_rd_last);
    assign w_rd_addr  = {r_rb, (r_state == S_SEND) ? w_rd_next : r_rd_idx};

    assign w_set = {w_wr_last && r_wb, w_wr_last && !r_wb};
    assign w_clr = {w_release && r_rb, w_release && !r_rb};

    always_ff @(posedge clock) begin
        if (w_wr_ok) begin
            r_mem[{r_wb, r_wr_idx}] <= dataIn;
        end
        if (w_rd_issue) begin
            r_rdata <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb     <= 1'b0;
            r_wr_idx <= '0;
        end else if (w_wr_ok) begin
            if (w_wr_last) begin
                r_wb     <= ~r_wb;
                r_wr_idx <= '0;
            end else begin
                r_wr_idx <= r_wr_idx + AW'(1);
            end
        end
    end

    // Set and clear always target different banks, so both may apply.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full & ~w_clr) | w_set;
        end
    end

`ifdef PIXLOADER_OVERFLOW_EN
    logic r_overflow;
    logic w_wr_drop;

    assign w_wr_drop = w_data_wr && r_full[r_wb];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_wr_drop) begin
            r_overflow <= 1'b1;
        end else if (wr_en && (addr == 8'h08) && dataIn[0]) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_overflow = r_overflow;
`else
    assign w_overflow = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rb     <= 1'b0;
            r_rd_idx <= '0;
            r_bi     <= 2'd0;
            r_shift  <= '0;
            r_valid  <= 1'b0;
            r_start  <= 1'b0;
            r_end    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_full[r_rb]) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_shift <= r_rdata;
                    r_bi    <= 2'd0;
                    r_valid <= 1'b1;
                    r_start <= (r_rd_idx == '0);
                    r_end   <= 1'b0;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (pix_ready) begin
                        if (r_bi == 2'd3) begin
                            r_valid <= 1'b0;
                            r_start <= 1'b0;
                            r_end   <= 1'b0;
                            if (w_rd_last) begin
                                r_rb     <= ~r_rb;
                                r_rd_idx <= '0;
                                r_state  <= S_IDLE;
                            end else begin
                                r_rd_idx <= w_rd_next;
                                r_state  <= S_FETCH;
                            end
                        end else begin
                            r_bi    <= r_bi + 2'd1;
                            r_shift <= {8'h00, r_shift[31:8]};
                            r_start <= 1'b0;
                            r_end   <= w_rd_last && (r_bi == 2'd2);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pix_out     = r_shift[7:0];
    assign pix_valid   = r_valid;
    assign block_start = r_start;
    assign block_end   = r_end;

    assign w_wr_idx6 = 6'(r_wr_idx);
    assign w_status  = {22'd0, w_wr_idx6, w_overflow,
                        r_full[1], r_full[0], !r_full[r_wb]};

    always_comb begin
        dataOut = 32'd0;
        if (rd_en && (addr == 8'h00)) begin
            dataOut = w_status;
        end
    end

endmodule

// File: tb/tb_mpeg2_pixel_loader.sv
// Self-checking bench for mpeg2_pixel_loader against a pixel-queue model.
// Honours PIXLOADER_OVERFLOW_EN when computing expected STATUS.
module tb_mpeg2_pixel_loader;

    localparam int W = 16;

`ifdef PIXLOADER_OVERFLOW_EN
    localparam logic [31:0] ST_OVF = 32'h0000_000E;
`else
    localparam logic [31:0] ST_OVF = 32'h0000_0006;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        pix_ready;
    logic        block_start;
    logic        block_end;

    always #5 clock = ~clock;

    mpeg2_pixel_loader #(.WORDS_PER_BLOCK(W)) dut (
        .clock(clock), .reset(reset), .addr(addr),
        .rd_en(rd_en), .wr_en(wr_en), .dataIn(dataIn),
        .dataOut(dataOut), .pix_out(pix_out),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .block_start(block_start), .block_end(block_end)
    );

    typedef struct {
        logic [7:0] p;
        logic       s;
        logic       e;
    } pix_t;

    int total = 0;
    int bad = 0;
    pix_t exp_q[$];
    logic [31:0] cur_words[$];
    logic mfull[2];
    int mwb, mrb;
    logic movf;
    int acc_cnt = 0;
    int cyc = 0;
    int start_cycs[$];
    int end_cycs[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] exp_status();
        return {22'd0, 6'(cur_words.size()), movf,
                mfull[1], mfull[0], !mfull[mwb]};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cur_words.delete();
        mfull[0] = 1'b0;
        mfull[1] = 1'b0;
        mwb = 0;
        mrb = 0;
        movf = 1'b0;
    endtask

    // Model decides at drive time, so a write racing a release sees full.
    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        if (a == 8'h04) begin
            if (!mfull[mwb]) begin
                cur_words.push_back(d);
                if (cur_words.size() == W) begin
                    for (int w = 0; w < W; w++) begin
                        for (int b = 0; b < 4; b++) begin
                            pix_t e;
                            logic [31:0] wd;
                            wd = cur_words[w];
                            e.p = wd[8*b +: 8];
                            e.s = (w == 0) && (b == 0);
                            e.e = (w == W - 1) && (b == 3);
                            exp_q.push_back(e);
                        end
                    end
                    cur_words.delete();
                    mfull[mwb] = 1'b1;
                    mwb ^= 1;
                end
            end else begin
`ifdef PIXLOADER_OVERFLOW_EN
                movf = 1'b1;
`endif
            end
        end
`ifdef PIXLOADER_OVERFLOW_EN
        if (a == 8'h08 && d[0]) movf = 1'b0;
`endif
        addr = a;
        dataIn = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        addr = 8'h00;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] v);
        addr = a;
        rd_en = 1'b1;
        #1;
        v = dataOut;
        rd_en = 1'b0;
        addr = 8'h00;
    endtask

    task automatic drain(input bit toggle, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pix_valid) && n < budget) begin
            pix_ready = toggle ? (n % 3 == 0) : 1'b1;
            tick();
            n++;
        end
        pix_ready = 1'b1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    logic stall_prev = 1'b0;
    logic [7:0] pp;
    logic ps, pe;

    always @(negedge clock) begin
        pix_t e;
        cyc++;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(pix_valid), 32'd1);
                chk("hold_pix", 32'(pix_out), 32'(pp));
                chk("hold_start", 32'(block_start), 32'(ps));
                chk("hold_end", 32'(block_end), 32'(pe));
            end
            if (pix_valid && block_start && !stall_prev)
                start_cycs.push_back(cyc);
            if (pix_valid && pix_ready) begin
                chk("pix_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pix_val", 32'(pix_out), 32'(e.p));
                    chk("pix_start", 32'(block_start), 32'(e.s));
                    chk("pix_end", 32'(block_end), 32'(e.e));
                    acc_cnt++;
                    if (e.e) begin
                        mfull[mrb] = 1'b0;
                        mrb ^= 1;
                        end_cycs.push_back(cyc);
                    end
                end
            end
            stall_prev = pix_valid && !pix_ready;
            pp = pix_out;
            ps = block_start;
            pe = block_end;
        end
    end

    initial begin
        logic [31:0] v;
        logic [31:0] wd;
        int base;
        int n;

        reset = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr = 8'h00;
        dataIn = 32'd0;
        pix_ready = 1'b0;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;

        @(negedge clock);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_start", 32'(block_start), 32'd0);
        chk("rst_end", 32'(block_end), 32'd0);
        chk("rst_pix", 32'(pix_out), 32'd0);
        bus_rd(8'h00, v);
        chk("rst_status", v, 32'h0000_0001);
        tick();

        // Ramp block and first-pixel latency
        pix_ready = 1'b1;
        base = acc_cnt;
        for (int k = 0; k < W; k++) begin
            wd = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            bus_wr(8'h04, wd);
        end
        @(negedge clock);
        chk("lat_idle", 32'(pix_valid), 32'd0);
        @(negedge clock);
        chk("lat_fetch", 32'(pix_valid), 32'd0);
        @(negedge clock);
        chk("lat_send", 32'(pix_valid), 32'd1);
        chk("lat_start", 32'(block_start), 32'd1);
        chk("lat_pix", 32'(pix_out), 32'h00);
        drain(1'b0, 2000);
        chk("ramp_count", 32'(acc_cnt - base), 32'd64);

        // Both banks full, then one more write overflows
        pix_ready = 1'b0;
        base = acc_cnt;
        for (int k = 0; k < 2*W; k++) bus_wr(8'h04, $urandom);
        bus_wr(8'h04, 32'd0);
        bus_rd(8'h00, v);
        chk("st_ovf", v, ST_OVF);
        chk("st_ovf_model", v, exp_status());
        tick();
        bus_wr(8'h08, 32'd1);
        bus_rd(8'h00, v);
        chk("st_clr", v, 32'h0000_0006);
        tick();
        drain(1'b0, 2000);
        chk("ovf_count", 32'(acc_cnt - base), 32'd128);

        // Back-pressure: ready 1-on/2-off
        pix_ready = 1'b0;
        base = acc_cnt;
        for (int k = 0; k < W; k++) bus_wr(8'h04, $urandom);
        drain(1'b1, 3000);
        chk("stall_count", 32'(acc_cnt - base), 32'd64);

        // Second bank filled while first streams
        start_cycs.delete();
        end_cycs.delete();
        pix_ready = 1'b1;
        base = acc_cnt;
        for (int k = 0; k < 2*W; k++) bus_wr(8'h04, $urandom);
        drain(1'b0, 2000);
        chk("pp_count", 32'(acc_cnt - base), 32'd128);
        chk("pp_starts", 32'(start_cycs.size()), 32'd2);
        chk("pp_ends", 32'(end_cycs.size()), 32'd2);
        if (start_cycs.size() > 1 && end_cycs.size() > 0)
            chk("pp_gap", 32'(start_cycs[1] - end_cycs[0]), 32'd3);

        // Reset at pixel 20
        pix_ready = 1'b1;
        base = acc_cnt;
        for (int k = 0; k < W; k++) bus_wr(8'h04, $urandom);
        n = 0;
        while (acc_cnt - base < 20 && n < 500) begin
            tick();
            n++;
        end
        chk("mid_reached", 32'(acc_cnt - base), 32'd20);
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_valid", 32'(pix_valid), 32'd0);
        bus_rd(8'h00, v);
        chk("mid_status", v, 32'h0000_0001);
        tick();
        base = acc_cnt;
        for (int k = 0; k < W; k++) bus_wr(8'h04, $urandom);
        drain(1'b0, 2000);
        chk("refill_count", 32'(acc_cnt - base), 32'd64);

        // Partial block and address decode
        for (int k = 0; k < 5; k++) bus_wr(8'h04, $urandom);
        bus_rd(8'h00, v);
        chk("st_part", v, 32'h0000_0051);
        chk("st_part_model", v, exp_status());
        bus_rd(8'h10, v);
        chk("rd_unmapped", v, 32'd0);
        bus_rd(8'h04, v);
        chk("rd_data_addr", v, 32'd0);
        addr = 8'h00;
        rd_en = 1'b0;
        #1;
        chk("rd_no_strobe", dataOut, 32'd0);
        tick();
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
